port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter_pkg.sv | 18 +
 rtl/port_arbiter_rr.sv | 41 ++++
 rtl/port_arbiter.sv | 159 +++++++++++++++
 tb/tb_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_arbiter_pkg.sv
// Shared parameter defaults and small helpers for the port arbiter.
package port_arbiter_pkg;

    // Bus width of addresses and data on the port bus.
    localparam int unsigned DEF_WORD_WIDTH  = 16;
    // Port address whose write stops the machine.
    localparam int unsigned DEF_HALT_PORT   = 0;
    // Cycles a read waits after issue before sampling the device.
    localparam int unsigned DEF_WAIT_CYCLES = 1;
    // Width of the read wait counter (WAIT_CYCLES is at most 15).
    localparam int unsigned WAIT_CNT_W      = 4;

    // Requester index to one-hot two-bit vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/port_arbiter_rr.sv
// Two-way round-robin grant: combinational one-hot grant, priority pointer
// that moves only when the grant is actually taken (update strobe).
module rr_arbiter2
    import port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Requester that wins when both ask; 0 after reset.
    logic prio_q;
    logic prio_d;

    // Grant the lone requester, or the one holding priority on a tie.
    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (req == 2'b11) begin
            grant = onehot2(prio_q);
        end else begin
            grant = req;
        end
        // Whoever is granted loses priority to the other requester.
        if (update && (grant != 2'b00)) begin
            prio_d = grant[0];
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Port bus arbiter: two requesters (CPU, debug loader) share one port device.
// Handshake: a requester raises req[i] with we/addr/wdata stable and holds it
// until ack[i] pulses for one cycle; rdata is valid in that ack cycle. The
// device sees one-cycle portget/portset strobes with portaddr/portval valid
// in the same cycle, and returns read data on portout WAIT_CYCLES later.
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned HALT_PORT   = DEF_HALT_PORT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [WORD_WIDTH-1:0] addr0,
    input  logic [WORD_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic [1:0]            ack,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic [WORD_WIDTH-1:0] portaddr,
    output logic [WORD_WIDTH-1:0] portval,
    output logic                  portget,
    output logic                  portset,
    input  logic [WORD_WIDTH-1:0] portout,
    output logic                  halted,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_idx_q, gnt_idx_d;
    logic                  we_q, we_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            ack_q, ack_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic [WORD_WIDTH-1:0] portaddr_q, portaddr_d;
    logic [WORD_WIDTH-1:0] portval_q, portval_d;
    logic                  portget_q, portget_d;
    logic                  portset_q, portset_d;
    logic                  halted_q, halted_d;

    logic [1:0]            grant;
    logic                  grant_en;
    logic                  sel;

    // A grant is taken only from IDLE and never once halted.
    assign grant_en = (state_q == S_IDLE) && !halted_q && (req != 2'b00);
    assign sel      = grant[1];

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (grant_en),
        .grant  (grant)
    );

    // Next-state and registered-output logic. portaddr/portval double as the
    // latched transaction, so they naturally hold outside ISSUE.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        rdata_d    = rdata_q;
        portaddr_d = portaddr_q;
        portval_d  = portval_q;
        portget_d  = 1'b0;
        portset_d  = 1'b0;
        halted_d   = halted_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    gnt_idx_d  = sel;
                    we_d       = we[sel];
                    portaddr_d = sel ? addr1 : addr0;
                    portval_d  = sel ? wdata1 : wdata0;
                    portset_d  = we[sel];
                    portget_d  = !we[sel];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    ack_d    = onehot2(gnt_idx_q);
                    halted_d = halted_q | (portaddr_q == WORD_WIDTH'(HALT_PORT));
                    state_d  = S_RESP;
                end else begin
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = portout;
                    ack_d   = onehot2(gnt_idx_q);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_idx_q  <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 2'b00;
            rdata_q    <= '0;
            portaddr_q <= '0;
            portval_q  <= '0;
            portget_q  <= 1'b0;
            portset_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            portaddr_q <= portaddr_d;
            portval_q  <= portval_d;
            portget_q  <= portget_d;
            portset_q  <= portset_d;
            halted_q   <= halted_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign portaddr  = portaddr_q;
    assign portval   = portval_q;
    assign portget   = portget_q;
    assign portset   = portset_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a cycle-indexed reference model.
module tb_port_arbiter;

    localparam int W      = 16;
    localparam int WAITC  = 1;
    localparam int HALT_P = 0;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [W-1:0]  addr0, addr1, wdata0, wdata1;
    logic [1:0]    ack;
    logic [W-1:0]  rdata, portaddr, portval, portout;
    logic          portget, portset, halted;
    logic [1:0]    dbg_state;

    int n_checks;
    int n_errors;

    port_arbiter #(.WORD_WIDTH(W), .WAIT_CYCLES(WAITC), .HALT_PORT(HALT_P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .portaddr  (portaddr),
        .portval   (portval),
        .portget   (portget),
        .portset   (portset),
        .portout   (portout),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycles are numbered; a grant taken at the end of IDLE cycle c makes
    // cycle c+1 the strobe cycle (k=0). Writes ack at k=1, reads at
    // k=WAITC+1, with portout taken at the end of k=WAITC.
    int           cyc_n, m_gedge, m_lat, kp, kc;
    bit           m_busy, m_we, m_g, m_prio, prev_idle;
    logic [W-1:0] m_addr;
    logic [1:0]   e_ack;
    logic [W-1:0] e_rdata, e_paddr, e_pval;
    logic         e_get, e_set, e_halted;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_n = 0; m_gedge = 0; m_lat = 0; m_busy = 0; m_we = 0; m_g = 0; m_prio = 0;
            m_addr = '0; e_ack = 2'b00; e_rdata = '0; e_paddr = '0; e_pval = '0;
            e_get = 0; e_set = 0; e_halted = 0;
        end else begin
            kp = cyc_n - m_gedge;
            prev_idle = !m_busy || (kp > m_lat);
            if (!prev_idle) begin
                if (!m_we && kp == WAITC) e_rdata = portout;
                if (m_we && kp == 0 && m_addr == W'(HALT_P)) e_halted = 1'b1;
            end
            if (prev_idle) begin
                m_busy = 0;
                if (req != 2'b00 && !e_halted) begin
                    m_g     = (req == 2'b11) ? m_prio : req[1];
                    m_prio  = !m_g;
                    m_we    = we[m_g];
                    m_addr  = m_g ? addr1 : addr0;
                    e_paddr = m_addr;
                    e_pval  = m_g ? wdata1 : wdata0;
                    m_lat   = m_we ? 1 : WAITC + 1;
                    m_gedge = cyc_n + 1;
                    m_busy  = 1;
                end
            end
            cyc_n++;
            kc    = cyc_n - m_gedge;
            e_set = m_busy && kc == 0 && m_we;
            e_get = m_busy && kc == 0 && !m_we;
            e_ack = (m_busy && kc == m_lat) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("m_ack", 32'(ack), 32'(e_ack));
            chk("m_rdata", 32'(rdata), 32'(e_rdata));
            chk("m_portaddr", 32'(portaddr), 32'(e_paddr));
            chk("m_portval", 32'(portval), 32'(e_pval));
            chk("m_portget", 32'(portget), 32'(e_get));
            chk("m_portset", 32'(portset), 32'(e_set));
            chk("m_halted", 32'(halted), 32'(e_halted));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_fields(input int i, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        we[i] = w;
        if (i == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
        chk({tag, "_portaddr"}, 32'(portaddr), 0);
        chk({tag, "_portval"}, 32'(portval), 0);
        chk({tag, "_portget"}, 32'(portget), 0);
        chk({tag, "_portset"}, 32'(portset), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
    endtask

    int got;
    int first_ack;
    int ord[4];
    int exp_ord[4];

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        portout = 16'hBEEF;
        exp_ord = '{0, 1, 0, 1};
        ord = '{9, 9, 9, 9};

        // Reset state.
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Requester 0 writes 0x42 to port 5.
        req[0] = 1'b1; set_fields(0, 1'b1, 16'd5, 16'h0042);
        @(negedge clk);
        chk("t1_portset", 32'(portset), 1);
        chk("t1_portget", 32'(portget), 0);
        chk("t1_portaddr", 32'(portaddr), 5);
        chk("t1_portval", 32'(portval), 32'h42);
        @(negedge clk);
        chk("t1_ack", 32'(ack), 32'b01);
        chk("t1_halted", 32'(halted), 0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", 32'(ack), 0);
        chk("t1_portset_off", 32'(portset), 0);
        @(negedge clk);

        // Requester 1 reads port 3, device returns 0xBEEF.
        req[1] = 1'b1; set_fields(1, 1'b0, 16'd3, 16'h0000);
        @(negedge clk);
        chk("t2_portget", 32'(portget), 1);
        chk("t2_portaddr", 32'(portaddr), 3);
        @(negedge clk);
        chk("t2_no_early_ack", 32'(ack), 0);
        chk("t2_portget_once", 32'(portget), 0);
        @(negedge clk);
        chk("t2_ack", 32'(ack), 32'b10);
        chk("t2_rdata", 32'(rdata), 32'hBEEF);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Both request continuously: grants alternate.
        set_fields(0, 1'b1, 16'd7, 16'h0A0A);
        set_fields(1, 1'b1, 16'd9, 16'h0B0B);
        req = 2'b11;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            chk("t3_excl", 32'(portget & portset), 0);
            if (ack != 2'b00) begin
                ord[got] = int'(ack[1]);
                got++;
            end
        end
        req = 2'b00;
        chk("t3_count", 32'(got), 4);
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(ord[i]), 32'(exp_ord[i]));
        repeat (2) @(negedge clk);

        // Write to the halt port with requester 1 pending.
        set_fields(0, 1'b1, 16'd0, 16'h1234);
        set_fields(1, 1'b0, 16'd3, 16'h0000);
        req = 2'b11;
        @(negedge clk);
        chk("t4_portset", 32'(portset), 1);
        @(negedge clk);
        chk("t4_ack", 32'(ack), 32'b01);
        chk("t4_halted", 32'(halted), 1);
        req[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t4_no_ack", 32'(ack), 0);
            chk("t4_no_strobe", 32'(portget | portset), 0);
            chk("t4_sticky", 32'(halted), 1);
        end
        #3 rst_n = 1'b0; req = 2'b00;
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Requester 0 read (priority moves to 1), reset during its WAIT.
        req[0] = 1'b1; set_fields(0, 1'b0, 16'd3, 16'h0000);
        @(negedge clk);
        chk("t5_portget", 32'(portget), 1);
        @(negedge clk);
        chk("t5_wait_no_ack", 32'(ack), 0);
        #3 rst_n = 1'b0; req = 2'b00;
        #1 chk_all_zero("t5_async");
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_ack", 32'(ack), 0);
            chk("t5_no_strobe", 32'(portget | portset), 0);
        end
        set_fields(0, 1'b1, 16'd7, 16'h0001);
        set_fields(1, 1'b1, 16'd9, 16'h0002);
        req = 2'b11;
        first_ack = 0;
        for (int c = 0; c < 10 && first_ack == 0; c++) begin
            @(negedge clk);
            if (ack != 2'b00) first_ack = int'(ack);
        end
        req = 2'b00;
        chk("t5_rr_reset", 32'(first_ack), 32'b01);
        repeat (2) @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            portout = W'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        req[i] = 1'b1;
                        set_fields(i, 1'($urandom_range(0, 1)), W'($urandom_range(0, 40)), W'($urandom));
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    set_fields(i, 1'($urandom_range(0, 1)), W'($urandom_range(0, 40)), W'($urandom));
                end
            end
            if ((halted && $urandom_range(0, 15) == 0) || $urandom_range(0, 499) == 0) begin
                #3 rst_n = 1'b0; req = 2'b00;
                @(negedge clk);
                #3 rst_n = 1'b1;
            end
        end
        req = 2'b00;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
